// File: rtl/mc_control_fsm.sv
// Main control FSM for a multicycle CPU: sequences fetch/decode/execute and
// drives every datapath enable and mux select straight from the current state.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t state_r;
    state_t next_state_s;

    assign state = state_r;

    // State register; reset always returns to FETCH, aborting any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control decode; anything not driven in a state stays 0.
    always_comb begin
        next_state_s = S_FETCH;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSource     = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        case (state_r)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    next_state_s = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    next_state_s = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    next_state_s = S_BRANCH;
                end else if (opcode == OP_J) begin
                    next_state_s = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    next_state_s = S_ADDIEX;
                end else begin
                    next_state_s = S_FETCH;
                    illegal_op   = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // IR still holds the opcode here, so it can pick load vs store again.
                if (opcode == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                next_state_s = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                next_state_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class, memory stalls,
// an illegal opcode and a mid-instruction reset, checking state and all controls.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Control vector layout:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,ALUSrcA,
    //  ALUSrcB,ALUOp,PCSource,instr_done,illegal_op}
    localparam logic [17:0] C_FETCH      = {10'b1001001000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_FETCH_WAIT = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_DECODE     = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_DECODE_ILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [17:0] C_MEMADR     = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_MEMRD      = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_MEMWB      = {10'b0000010010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] C_MEMWR      = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] C_MEMWR_WAIT = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_EXEC       = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_RWB        = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] C_BRANCH     = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [17:0] C_JUMP       = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [17:0] C_ADDIEX     = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] C_ADDIWB     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};

    logic [17:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

    mc_control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check state and controls mid-cycle, then advance one clock.
    task automatic run_cyc(input string tag, input logic [3:0] exp_state, input logic [17:0] exp_ctrl);
        @(negedge clk);
        check_eq({tag, ".state"}, {28'd0, state}, {28'd0, exp_state});
        check_eq({tag, ".ctrl"}, {14'd0, ctrl}, {14'd0, exp_ctrl});
        @(posedge clk);
        #1;
    endtask

    // Directed sequence of instruction flows.
    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        run_cyc("reset", 4'd0, C_FETCH);
        rst = 1'b0;

        opcode = 6'h23;
        run_cyc("lw_fetch",  4'd0, C_FETCH);
        run_cyc("lw_decode", 4'd1, C_DECODE);
        run_cyc("lw_memadr", 4'd2, C_MEMADR);
        run_cyc("lw_memrd",  4'd3, C_MEMRD);
        run_cyc("lw_memwb",  4'd4, C_MEMWB);

        opcode    = 6'h2B;
        mem_ready = 1'b0;
        run_cyc("fetch_stall", 4'd0, C_FETCH_WAIT);
        mem_ready = 1'b1;
        run_cyc("sw_fetch",  4'd0, C_FETCH);
        run_cyc("sw_decode", 4'd1, C_DECODE);
        run_cyc("sw_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cyc("sw_memwr_wait", 4'd5, C_MEMWR_WAIT);
        end
        mem_ready = 1'b1;
        run_cyc("sw_memwr", 4'd5, C_MEMWR);

        opcode = 6'h00;
        run_cyc("r_fetch",  4'd0, C_FETCH);
        run_cyc("r_decode", 4'd1, C_DECODE);
        run_cyc("r_exec",   4'd6, C_EXEC);
        run_cyc("r_rwb",    4'd7, C_RWB);

        opcode = 6'h08;
        run_cyc("addi_fetch",  4'd0,  C_FETCH);
        run_cyc("addi_decode", 4'd1,  C_DECODE);
        run_cyc("addi_ex",     4'd10, C_ADDIEX);
        run_cyc("addi_wb",     4'd11, C_ADDIWB);

        opcode = 6'h04;
        run_cyc("beq_fetch",  4'd0, C_FETCH);
        run_cyc("beq_decode", 4'd1, C_DECODE);
        run_cyc("beq_branch", 4'd8, C_BRANCH);

        opcode = 6'h02;
        run_cyc("j_fetch",  4'd0, C_FETCH);
        run_cyc("j_decode", 4'd1, C_DECODE);
        run_cyc("j_jump",   4'd9, C_JUMP);

        opcode = 6'h3F;
        run_cyc("ill_fetch",  4'd0, C_FETCH);
        run_cyc("ill_decode", 4'd1, C_DECODE_ILL);
        run_cyc("ill_after",  4'd0, C_FETCH);

        opcode = 6'h23;
        run_cyc("abort_decode", 4'd1, C_DECODE);
        run_cyc("abort_memadr", 4'd2, C_MEMADR);
        mem_ready = 1'b0;
        run_cyc("abort_stall", 4'd3, C_MEMRD);
        rst = 1'b1;
        run_cyc("abort_rst", 4'd3, C_MEMRD);
        run_cyc("abort_fetch", 4'd0, C_FETCH_WAIT);
        rst       = 1'b0;
        mem_ready = 1'b1;
        run_cyc("post_abort", 4'd0, C_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
